// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stream and a multi-cycle unit. Writeback always wins; multi-cycle
// results queue in a small FIFO and drain into idle port cycles. Queued entries
// made stale by a younger writeback to the same register are squashed.
// Optional macro WB_PORT_ARB_FWD_EN adds a combinational forwarding lookup
// (rd_addr / rd_hit / rd_data) into the live FIFO entries.
module wb_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       wb_dest,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    mc_valid,
  input  logic [ADDR_W-1:0]       mc_dest,
  input  logic [DATA_W-1:0]       mc_data,
  output logic                    mc_ready,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_dest,
  output logic [DATA_W-1:0]       rf_data,
  output logic [(2**ADDR_W)-1:0]  busy_mask,
`ifdef WB_PORT_ARB_FWD_EN
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_hit,
  output logic [DATA_W-1:0]       rd_data,
`endif
  output logic                    stall_req
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  // FIFO storage; kill flags live in flops because every entry may be
  // squashed in parallel by a writeback.
  logic [ADDR_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  kill_reg;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [SC_W-1:0]   starve_reg, starve_next;
  logic              stall_reg;
  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_dest_reg;
  logic [DATA_W-1:0] rf_data_reg;

  logic              empty, full, mc_hs;
  logic              head_kill, head_live, discard, pop, bypass, push, deq;
  logic [DEPTH-1:0]  live, wb_match;
  logic [PTR_W-1:0]  age [DEPTH];
  logic [NREG-1:0]   entry_mask [DEPTH];

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign mc_ready  = !full && !rst;
  assign mc_hs     = mc_valid && mc_ready;
  assign head_kill = kill_reg[head_reg];
  assign head_live = !empty && !head_kill;
  // A killed head leaves without using the port, even alongside a wb write.
  assign discard   = !empty && head_kill;
  assign pop       = !wb_en && head_live;
  assign bypass    = !wb_en && empty && mc_hs;
  assign push      = mc_hs && !bypass;
  assign deq       = pop || discard;

  // Per-entry occupancy, liveness, squash match and busy contribution.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign age[gi]        = PTR_W'(gi) - head_reg;
      assign live[gi]       = ({1'b0, age[gi]} < count_reg) && !kill_reg[gi];
      assign wb_match[gi]   = wb_en && (dest_mem[gi] == wb_dest);
      assign entry_mask[gi] = live[gi] ? (NREG'(1) << dest_mem[gi]) : '0;
    end
  endgenerate

  // OR together the destinations of all live entries.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_mask = busy_mask | entry_mask[i];
    end
  end

  // Port selection: writeback, then live head, then bypass, else idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg   <= 1'b0;
      rf_dest_reg <= '0;
      rf_data_reg <= '0;
    end else if (wb_en) begin
      rf_we_reg   <= 1'b1;
      rf_dest_reg <= wb_dest;
      rf_data_reg <= wb_data;
    end else if (pop) begin
      rf_we_reg   <= 1'b1;
      rf_dest_reg <= dest_mem[head_reg];
      rf_data_reg <= data_mem[head_reg];
    end else if (bypass) begin
      rf_we_reg   <= 1'b1;
      rf_dest_reg <= mc_dest;
      rf_data_reg <= mc_data;
    end else begin
      rf_we_reg   <= 1'b0;
    end
  end

  // FIFO payload write; contents are meaningless outside the occupied range.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[tail_reg] <= mc_dest;
      data_mem[tail_reg] <= mc_data;
    end
  end

  // Pointers, occupancy count and kill flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      kill_reg  <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (deq)  head_reg <= head_reg + PTR_W'(1);
      case ({push, deq})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tail_reg == PTR_W'(i))) begin
          // An entry arriving with the same dest as this cycle's wb is born dead.
          kill_reg[i] <= wb_en && (mc_dest == wb_dest);
        end else if (wb_match[i]) begin
          kill_reg[i] <= 1'b1;
        end
      end
    end
  end

  // Starvation counter: counts blocked cycles of a live head, saturating.
  always_comb begin
    starve_next = starve_reg;
    if (empty || deq) begin
      starve_next = '0;
    end else if (head_live && (starve_reg != SC_W'(STARVE_LIMIT))) begin
      starve_next = starve_reg + SC_W'(1);
    end
  end

  // Counter and stall request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg <= '0;
      stall_reg  <= 1'b0;
    end else begin
      starve_reg <= starve_next;
      stall_reg  <= (starve_next == SC_W'(STARVE_LIMIT));
    end
  end

  assign rf_we     = rf_we_reg;
  assign rf_dest   = rf_dest_reg;
  assign rf_data   = rf_data_reg;
  assign stall_req = stall_reg;

`ifdef WB_PORT_ARB_FWD_EN
  logic [PTR_W-1:0] fwd_slot;

  // Scan oldest to youngest so the youngest matching live entry wins.
  always_comb begin
    rd_hit   = 1'b0;
    rd_data  = '0;
    fwd_slot = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_slot = head_reg + PTR_W'(k);
      if (live[fwd_slot] && (dest_mem[fwd_slot] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = data_mem[fwd_slot];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter with
// default parameters (DATA_W=16, ADDR_W=3, DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        mc_valid;
  logic [2:0]  mc_dest;
  logic [15:0] mc_data;
  logic        mc_ready;
  logic        rf_we;
  logic [2:0]  rf_dest;
  logic [15:0] rf_data;
  logic [7:0]  busy_mask;
  logic        stall_req;
`ifdef WB_PORT_ARB_FWD_EN
  logic [2:0]  rd_addr;
  logic        rd_hit;
  logic [15:0] rd_data;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  wb_port_arbiter #(
    .DATA_W(16), .ADDR_W(3), .DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (wb_en),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .mc_valid  (mc_valid),
    .mc_dest   (mc_dest),
    .mc_data   (mc_data),
    .mc_ready  (mc_ready),
    .rf_we     (rf_we),
    .rf_dest   (rf_dest),
    .rf_data   (rf_data),
    .busy_mask (busy_mask),
`ifdef WB_PORT_ARB_FWD_EN
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
`endif
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [2:0] wd, input logic [15:0] wdat,
                       input logic mv, input logic [2:0] md, input logic [15:0] mdat);
    wb_en = we; wb_dest = wd; wb_data = wdat;
    mc_valid = mv; mc_dest = md; mc_data = mdat;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    $display("cyc=%0d rst=%0b wb=%0b/%0d/%h mc=%0b/%0d/%h -> rf=%0b/%0d/%h busy=%h stall=%0b rdy=%0b",
             cycle, rst, wb_en, wb_dest, wb_data, mc_valid, mc_dest, mc_data,
             rf_we, rf_dest, rf_data, busy_mask, stall_req, mc_ready);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    tick(); tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", rf_we); end
    checks++; if (rf_dest !== 3'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", rf_dest); end
    checks++; if (rf_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", rf_data); end
    checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL reset_busy got %h want 00", busy_mask); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall_req); end
    checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", mc_ready); end
    rst = 1'b0;
    #1;
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %0b want 1", mc_ready); end
  endtask

  task automatic test_bypass();
    drive(0, 0, 16'h0, 1, 3'd5, 16'h1234);
    tick();
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL bypass_we got %0b want 1", rf_we); end
    checks++; if (rf_dest !== 3'd5) begin errors++; $display("FAIL bypass_dest got %0d want 5", rf_dest); end
    checks++; if (rf_data !== 16'h1234) begin errors++; $display("FAIL bypass_data got %h want 1234", rf_data); end
    checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL bypass_busy got %h want 00", busy_mask); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we got %0b want 0", rf_we); end
    checks++; if (rf_dest !== 3'd5 || rf_data !== 16'h1234) begin errors++; $display("FAIL idle_hold got %0d/%h want 5/1234", rf_dest, rf_data); end
  endtask

  task automatic test_starve();
    drive(1, 3'd7, 16'h1000, 1, 3'd2, 16'hAAAA); tick();
    checks++; if (rf_we !== 1'b1 || rf_dest !== 3'd7 || rf_data !== 16'h1000) begin errors++; $display("FAIL starve_wb0 got %0b/%0d/%h want 1/7/1000", rf_we, rf_dest, rf_data); end
    checks++; if (busy_mask !== 8'h04) begin errors++; $display("FAIL starve_busy1 got %h want 04", busy_mask); end
    checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL starve_ready1 got %0b want 1", mc_ready); end
    drive(1, 3'd7, 16'h1001, 1, 3'd3, 16'hBBBB); tick();
    checks++; if (busy_mask !== 8'h0C) begin errors++; $display("FAIL starve_busy2 got %h want 0c", busy_mask); end
    checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL starve_full_ready got %0b want 0", mc_ready); end
    drive(1, 3'd7, 16'h1002, 0, 0, 16'h0); tick();
    drive(1, 3'd7, 16'h1003, 0, 0, 16'h0); tick();
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL starve_early got %0b want 0", stall_req); end
    drive(1, 3'd7, 16'h1004, 0, 0, 16'h0); tick();
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL starve_stall got %0b want 1", stall_req); end
    drive(1, 3'd7, 16'h1005, 0, 0, 16'h0); tick();
    checks++; if (rf_we !== 1'b1 || rf_data !== 16'h1005) begin errors++; $display("FAIL stall_wb_wins got %0b/%h want 1/1005", rf_we, rf_data); end
    checks++; if (stall_req !== 1'b1 || busy_mask !== 8'h0C) begin errors++; $display("FAIL stall_hold got %0b/%h want 1/0c", stall_req, busy_mask); end
    drive(0, 0, 16'h0, 0, 0, 16'h0); tick();
    checks++; if (rf_we !== 1'b1 || rf_dest !== 3'd2 || rf_data !== 16'hAAAA) begin errors++; $display("FAIL drain1 got %0b/%0d/%h want 1/2/aaaa", rf_we, rf_dest, rf_data); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL stall_clear got %0b want 0", stall_req); end
    checks++; if (busy_mask !== 8'h08 || mc_ready !== 1'b1) begin errors++; $display("FAIL drain1_state got %h/%0b want 08/1", busy_mask, mc_ready); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_dest !== 3'd3 || rf_data !== 16'hBBBB) begin errors++; $display("FAIL drain2 got %0b/%0d/%h want 1/3/bbbb", rf_we, rf_dest, rf_data); end
    checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL drain2_busy got %h want 00", busy_mask); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL drain_idle got %0b want 0", rf_we); end
  endtask

  task automatic test_squash();
    drive(1, 3'd7, 16'h0700, 1, 3'd4, 16'h0101); tick();
    checks++; if (busy_mask !== 8'h10) begin errors++; $display("FAIL squash_busy_pre got %h want 10", busy_mask); end
    drive(1, 3'd4, 16'h0202, 0, 0, 16'h0); tick();
    checks++; if (rf_we !== 1'b1 || rf_dest !== 3'd4 || rf_data !== 16'h0202) begin errors++; $display("FAIL squash_wb got %0b/%0d/%h want 1/4/0202", rf_we, rf_dest, rf_data); end
    checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL squash_busy got %h want 00", busy_mask); end
    drive(0, 0, 16'h0, 0, 0, 16'h0); tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL squash_no_write got %0b want 0", rf_we); end
    checks++; if (rf_dest !== 3'd4 || rf_data !== 16'h0202) begin errors++; $display("FAIL squash_hold got %0d/%h want 4/0202", rf_dest, rf_data); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL squash_no_late got %0b want 0", rf_we); end
    // Same-cycle enqueue killed by a simultaneous writeback to the same register.
    drive(1, 3'd5, 16'h0505, 1, 3'd5, 16'h5555); tick();
    checks++; if (rf_dest !== 3'd5 || rf_data !== 16'h0505) begin errors++; $display("FAIL born_dead_wb got %0d/%h want 5/0505", rf_dest, rf_data); end
    checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL born_dead_busy got %h want 00", busy_mask); end
    drive(0, 0, 16'h0, 0, 0, 16'h0); tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL born_dead_no_write got %0b want 0", rf_we); end
    // FIFO must be empty again: a fresh result takes the bypass path.
    drive(0, 0, 16'h0, 1, 3'd6, 16'h0606); tick();
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    checks++; if (rf_we !== 1'b1 || rf_dest !== 3'd6 || rf_data !== 16'h0606) begin errors++; $display("FAIL squash_empty_bypass got %0b/%0d/%h want 1/6/0606", rf_we, rf_dest, rf_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 3'd7, 16'h7001, 1, 3'd1, 16'h1111); tick();
    drive(1, 3'd7, 16'h7002, 1, 3'd2, 16'h2222); tick();
    checks++; if (busy_mask !== 8'h06) begin errors++; $display("FAIL full_busy got %h want 06", busy_mask); end
    drive(0, 0, 16'h0, 1, 3'd3, 16'h3333);
    #1;
    checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", mc_ready); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_dest !== 3'd1 || rf_data !== 16'h1111) begin errors++; $display("FAIL full_pop1 got %0b/%0d/%h want 1/1/1111", rf_we, rf_dest, rf_data); end
    checks++; if (mc_ready !== 1'b1 || busy_mask !== 8'h04) begin errors++; $display("FAIL full_pop1_state got %0b/%h want 1/04", mc_ready, busy_mask); end
    tick();
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    checks++; if (rf_we !== 1'b1 || rf_dest !== 3'd2 || rf_data !== 16'h2222) begin errors++; $display("FAIL full_pop2 got %0b/%0d/%h want 1/2/2222", rf_we, rf_dest, rf_data); end
    checks++; if (busy_mask !== 8'h08) begin errors++; $display("FAIL full_push_busy got %h want 08", busy_mask); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_dest !== 3'd3 || rf_data !== 16'h3333) begin errors++; $display("FAIL full_pop3 got %0b/%0d/%h want 1/3/3333", rf_we, rf_dest, rf_data); end
    tick();
    checks++; if (rf_we !== 1'b0 || busy_mask !== 8'h00) begin errors++; $display("FAIL full_no_dup got %0b/%h want 0/00", rf_we, busy_mask); end
  endtask

  task automatic test_reset_mid();
    drive(1, 3'd7, 16'h7101, 1, 3'd1, 16'h1111); tick();
    drive(1, 3'd7, 16'h7102, 1, 3'd2, 16'h2222); tick();
    drive(1, 3'd7, 16'h7103, 0, 0, 16'h0); tick(); tick(); tick();
    checks++; if (stall_req !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL pre_reset got %0b/%0b want 1/1", stall_req, rf_we); end
    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 0, 16'h0); tick();
    checks++; if (rf_we !== 1'b0 || rf_dest !== 3'd0 || rf_data !== 16'h0) begin errors++; $display("FAIL mid_reset_rf got %0b/%0d/%h want 0/0/0000", rf_we, rf_dest, rf_data); end
    checks++; if (busy_mask !== 8'h00 || stall_req !== 1'b0) begin errors++; $display("FAIL mid_reset_state got %h/%0b want 00/0", busy_mask, stall_req); end
    rst = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_reset_write1 got %0b want 0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_reset_write2 got %0b want 0", rf_we); end
    drive(0, 0, 16'h0, 1, 3'd6, 16'h0666); tick();
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    checks++; if (rf_we !== 1'b1 || rf_dest !== 3'd6 || rf_data !== 16'h0666) begin errors++; $display("FAIL post_reset_bypass got %0b/%0d/%h want 1/6/0666", rf_we, rf_dest, rf_data); end
    tick();
  endtask

`ifdef WB_PORT_ARB_FWD_EN
  task automatic test_forward();
    rd_addr = 3'd1;
    drive(1, 3'd7, 16'h7201, 1, 3'd1, 16'h0011); tick();
    drive(1, 3'd7, 16'h7202, 1, 3'd1, 16'h0022); tick();
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    #1;
    checks++; if (rd_hit !== 1'b1 || rd_data !== 16'h0022) begin errors++; $display("FAIL fwd_youngest got %0b/%h want 1/0022", rd_hit, rd_data); end
    rd_addr = 3'd6;
    #1;
    checks++; if (rd_hit !== 1'b0 || rd_data !== 16'h0) begin errors++; $display("FAIL fwd_miss got %0b/%h want 0/0000", rd_hit, rd_data); end
    rd_addr = 3'd1;
    tick();
    checks++; if (rd_hit !== 1'b1 || rd_data !== 16'h0022 || rf_data !== 16'h0011) begin errors++; $display("FAIL fwd_after_pop got %0b/%h/%h want 1/0022/0011", rd_hit, rd_data, rf_data); end
    tick();
    checks++; if (rd_hit !== 1'b0 || rf_data !== 16'h0022) begin errors++; $display("FAIL fwd_drained got %0b/%h want 0/0022", rd_hit, rf_data); end
    tick();
  endtask
`endif

  initial begin
`ifdef WB_PORT_ARB_FWD_EN
    rd_addr = 3'd0;
`endif
    test_reset();
    test_bypass();
    test_starve();
    test_squash();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_PORT_ARB_FWD_EN
    test_forward();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
